// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation.
// Functions work on zero-extended 32-bit values; callers pass the live width
// and cast the result back to their pointer width.
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] width_mask(input int width);
        if (width >= PTR_MAX_W) return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b,
                                                      input int width);
        logic [PTR_MAX_W-1:0] bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

    // Prefix XOR from the MSB down, done with doubling shifts.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                      input int width);
        logic [PTR_MAX_W-1:0] b;
        b = g & width_mask(width);
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Plain N-flop synchroniser chain, asynchronous active-high reset to zero.
module sync_nff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side controller of the async FIFO: binary/Gray write pointers,
// read-pointer synchroniser, and registered full / almost-full / level /
// sticky overflow flags, all in the wclk domain.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int AFULL_THR   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wclk,
    input  logic              wreset,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray_async,
    input  logic              wovf_clr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wen_ram,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow
);

    localparam int            PW          = ADDR_W + 1;
    localparam int            DEPTH       = fifo_depth(ADDR_W);
    localparam int            AFULL_LVL_I = DEPTH - AFULL_THR;
    localparam logic [PW-1:0] AFULL_LVL   = PW'(AFULL_LVL_I);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_pat;

    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wreset),
        .d   (rptr_gray_async),
        .q   (rq)
    );

    assign wen_ram    = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wen_ram};
    assign wgray_next = PW'(bin2gray(32'(wbin_next), PW));
    assign rbin_s     = PW'(gray2bin(32'(rq), PW));
    assign level_next = wbin_next - rbin_s;
    assign waddr      = wbin[ADDR_W-1:0];

    // Full when the next write pointer sits exactly one lap ahead of the
    // synchronised read pointer: top two Gray bits inverted, rest equal.
    generate
        if (ADDR_W == 1) begin : g_pat_w1
            assign full_pat = ~rq;
        end else begin : g_pat_wn
            assign full_pat = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};
        end
    endgenerate

    // Binary and Gray write pointers advance together on every accepted write.
    always_ff @(posedge wclk or posedge wreset) begin
        if (wreset) begin
            wbin      <= '0;
            wptr_gray <= '0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
        end
    end

    // Status flags are registered from the same next-state values as the pointers.
    always_ff @(posedge wclk or posedge wreset) begin
        if (wreset) begin
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wfull        <= (wgray_next == full_pat);
            walmost_full <= (level_next >= AFULL_LVL);
            wlevel       <= level_next;
            if (winc && wfull)
                woverflow <= 1'b1;
            else if (wovf_clr)
                woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed scenarios plus random traffic, checked by
// a scoreboard fed from an occupancy-count reference model.
module tb_wptr_full_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AFT    = 1;
    localparam int SS     = 2;
    localparam int MODP   = 16;

    logic       wclk;
    logic       wreset;
    logic       winc;
    logic [3:0] rptr_gray_async;
    logic       wovf_clr;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wen_ram;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       woverflow;

    wptr_full_ctrl #(.ADDR_W(ADDR_W), .AFULL_THR(AFT), .SYNC_STAGES(SS)) dut (
        .wclk            (wclk),
        .wreset          (wreset),
        .winc            (winc),
        .rptr_gray_async (rptr_gray_async),
        .wovf_clr        (wovf_clr),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .wen_ram         (wen_ram),
        .wfull           (wfull),
        .walmost_full    (walmost_full),
        .wlevel          (wlevel),
        .woverflow       (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        int waddr;
        int gray;
        int full;
        int afull;
        int level;
        int ovf;
        int wen;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state: counts of items, not pointer bits
    int wcount;
    int rcnt;
    int m_full;
    int m_ovf;
    int hist[$];

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input int g);
        for (int i = 0; i < MODP; i++) if (to_gray(i) == g) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wcount = 0;
        rcnt   = 0;
        m_full = 0;
        m_ovf  = 0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(0);
    endtask

    // One wclk cycle of stimulus; the model predicts the state after the next edge.
    task automatic step(input bit w, input bit rd, input bit clr);
        int   used;
        int   rs;
        int   lvl;
        int   acc;
        exp_t e;
        @(negedge wclk);
        #1;
        if (rd && rcnt != wcount) rcnt = (rcnt + 1) % MODP;
        rptr_gray_async = 4'(to_gray(rcnt));
        winc     = w;
        wovf_clr = clr;
        used = hist.pop_front();
        hist.push_back(rcnt);
        acc  = (w && !m_full) ? 1 : 0;
        if (w && m_full) m_ovf = 1;
        else if (clr)    m_ovf = 0;
        wcount = (wcount + acc) % MODP;
        rs     = from_gray(to_gray(used));
        lvl    = (wcount - rs + MODP) % MODP;
        m_full = (lvl == DEPTH) ? 1 : 0;
        e.waddr = wcount % DEPTH;
        e.gray  = to_gray(wcount);
        e.full  = m_full;
        e.afull = (lvl >= DEPTH - AFT) ? 1 : 0;
        e.level = lvl;
        e.ovf   = m_ovf;
        e.wen   = (w && !m_full) ? 1 : 0;
        sbq.push_back(e);
    endtask

    // Monitor: compare DUT state shortly after each active edge.
    always @(posedge wclk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sb_waddr",  int'(waddr),        e.waddr);
            check("sb_gray",   int'(wptr_gray),    e.gray);
            check("sb_full",   int'(wfull),        e.full);
            check("sb_afull",  int'(walmost_full), e.afull);
            check("sb_level",  int'(wlevel),       e.level);
            check("sb_ovf",    int'(woverflow),    e.ovf);
            check("sb_wen",    int'(wen_ram),      e.wen);
        end
    end

    task automatic after_edge();
        @(posedge wclk);
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_waddr"}, int'(waddr),        0);
        check({tag, "_gray"},  int'(wptr_gray),    0);
        check({tag, "_full"},  int'(wfull),        0);
        check({tag, "_afull"}, int'(walmost_full), 0);
        check({tag, "_level"}, int'(wlevel),       0);
        check({tag, "_ovf"},   int'(woverflow),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  max_lvl;
        bit  saw_wrap;
        bit  saw_full;
        int  prev_gray;

        wreset = 1'b1;
        winc = 1'b0;
        wovf_clr = 1'b0;
        rptr_gray_async = '0;
        model_reset();
        #12;
        check_all_zero("rst");
        wreset = 1'b0;

        // fill to full with the read pointer parked at zero
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        after_edge();
        check("afull_after7", int'(walmost_full), 1);
        check("full_after7",  int'(wfull),        0);
        step(1, 0, 0);
        after_edge();
        check("full_after8",  int'(wfull),     1);
        check("level_after8", int'(wlevel),    8);
        check("waddr_after8", int'(waddr),     0);
        check("gray_after8",  int'(wptr_gray), 12);

        // writes attempted while full
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0);
            after_edge();
            check("ovf_wen",  int'(wen_ram),   0);
            check("ovf_gray", int'(wptr_gray), 12);
            check("ovf_set",  int'(woverflow), 1);
        end
        step(0, 0, 1);
        after_edge();
        check("ovf_clr", int'(woverflow), 0);

        // one read: full drops only at the third edge
        step(0, 1, 0);
        after_edge();
        check("lat_e1_full", int'(wfull), 1);
        step(0, 0, 0);
        after_edge();
        check("lat_e2_full", int'(wfull), 1);
        step(0, 0, 0);
        after_edge();
        check("lat_e3_full",  int'(wfull),  0);
        check("lat_e3_level", int'(wlevel), 7);

        // drain, then paced write/read pairs across a pointer wrap
        for (int i = 0; i < 12; i++) step(0, 1, 0);
        max_lvl   = 0;
        saw_wrap  = 0;
        saw_full  = 0;
        prev_gray = int'(wptr_gray);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            step(0, 1, 0);
            step(0, 0, 0);
            step(0, 0, 0);
            after_edge();
            if (int'(wlevel) > max_lvl) max_lvl = int'(wlevel);
            if (wfull) saw_full = 1;
        end
        check("inter_max_level", max_lvl, 0);
        check("inter_full_seen", int'(saw_full), 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0);
            after_edge();
            if (int'(wlevel) > max_lvl) max_lvl = int'(wlevel);
            if (wfull) saw_full = 1;
            if (prev_gray == 8 && int'(wptr_gray) == 0) saw_wrap = 1;
            prev_gray = int'(wptr_gray);
            step(0, 1, 0);
            step(0, 0, 0);
            step(0, 0, 0);
            after_edge();
            if (wfull) saw_full = 1;
        end
        check("wrap_1000_0000", int'(saw_wrap), 1);
        check("wrap_max_level", max_lvl, 1);
        check("wrap_full_seen", int'(saw_full), 0);

        // drain, build level 5, then reset asynchronously between edges
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        @(posedge wclk);
        #4;
        check("pre_rst_level", int'(wlevel), 5);
        wreset = 1'b1;
        winc = 1'b0;
        wovf_clr = 1'b0;
        rptr_gray_async = '0;
        model_reset();
        #1;
        check_all_zero("arst");
        check("arst_wen", int'(wen_ram), 0);
        wreset = 1'b0;
        step(1, 0, 0);
        after_edge();
        check("resume_waddr", int'(waddr), 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 9) == 0));
        end
        after_edge();
        after_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
